// File: rtl/instr_fetch_decode.sv
// Fetch/decode sequencer: FETCH -> WAIT_MEM -> DECODE -> ISSUE -> EXEC_WAIT; alu_start rises 3 cycles after mem_rd.
// Stalls on mem_valid / exec_done; with FETCH_TIMEOUT_EN defined a 16-cycle fetch stall sets fault and halts.
module instr_fetch_decode (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  output logic [7:0]  o_mem_addr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic        o_alu_start,
  output logic [3:0]  o_alu_op,
  output logic [3:0]  o_rd_addr,
  output logic [3:0]  o_rs1_addr,
  output logic [3:0]  o_rs2_addr,
  input  logic        i_exec_done,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_illegal,
  output logic [7:0]  o_retired,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_MEM  = 3'd2,
    S_DECODE    = 3'd3,
    S_ISSUE     = 3'd4,
    S_EXEC_WAIT = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [7:0]  r_retired;
  logic        r_mem_rd;
  logic        r_alu_start;
  logic        r_illegal;
  logic [3:0]  w_opcode;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0]  r_tmo_cnt;
  logic        r_fault;
`endif

  assign w_opcode = r_ir[15:12];

  // Strobes are set on the transition into their state so each is high for exactly that one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pc        <= 8'h00;
      r_ir        <= 16'h0000;
      r_retired   <= 8'h00;
      r_mem_rd    <= 1'b0;
      r_alu_start <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_tmo_cnt   <= 4'h0;
      r_fault     <= 1'b0;
`endif
    end else begin
      r_mem_rd    <= 1'b0;
      r_alu_start <= 1'b0;
      r_illegal   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT_MEM;
`ifdef FETCH_TIMEOUT_EN
          r_tmo_cnt <= 4'h0;
`endif
        end
        S_WAIT_MEM: begin
          if (i_mem_valid) begin
            r_ir    <= i_mem_data;
            r_state <= S_DECODE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_tmo_cnt == 4'hF) begin
            r_fault <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 4'h1;
          end
`endif
        end
        S_DECODE: begin
          if (w_opcode == 4'hF) begin
            r_state <= S_HALT;
          end else if (w_opcode >= 4'hC) begin
            r_illegal <= 1'b1;
            r_pc      <= r_pc + 8'h01;
            if (i_run) begin
              r_state  <= S_FETCH;
              r_mem_rd <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
            end
          end else begin
            r_state     <= S_ISSUE;
            r_alu_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_EXEC_WAIT;
        end
        S_EXEC_WAIT: begin
          if (i_exec_done) begin
            r_pc      <= r_pc + 8'h01;
            r_retired <= r_retired + 8'h01;
            if (i_run) begin
              r_state  <= S_FETCH;
              r_mem_rd <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_addr  = r_pc;
  assign o_mem_rd    = r_mem_rd;
  assign o_alu_start = r_alu_start;
  assign o_illegal   = r_illegal;
  assign o_alu_op    = r_ir[15:12];
  assign o_rd_addr   = r_ir[11:8];
  assign o_rs1_addr  = r_ir[7:4];
  assign o_rs2_addr  = r_ir[3:0];
  assign o_retired   = r_retired;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_HALT);
  assign o_halted    = (r_state == S_HALT);

`ifdef FETCH_TIMEOUT_EN
  assign o_fault = r_fault;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Scoreboarded bench for instr_fetch_decode: directed programs, memory and exec-unit responders,
// a monitor popping expected fetch addresses / issued instructions.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_run;
  logic [7:0]  o_mem_addr;
  logic        o_mem_rd;
  logic [15:0] i_mem_data;
  logic        i_mem_valid;
  logic        o_alu_start;
  logic [3:0]  o_alu_op;
  logic [3:0]  o_rd_addr;
  logic [3:0]  o_rs1_addr;
  logic [3:0]  o_rs2_addr;
  logic        i_exec_done;
  logic        o_busy;
  logic        o_halted;
  logic        o_illegal;
  logic [7:0]  o_retired;
  logic        o_fault;

  logic [15:0] prog [256];
  logic [7:0]  exp_fetch_q [$];
  logic [15:0] exp_issue_q [$];
  int          n_asserts = 0;
  int          n_fails   = 0;
  int          cyc       = 0;
  int          last_rd_cyc = 0;
  int          illegal_seen = 0;
  int          exec_lat = 1;
  bit          mem_en = 1'b1;

  instr_fetch_decode dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_run       (i_run),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd    (o_mem_rd),
    .i_mem_data  (i_mem_data),
    .i_mem_valid (i_mem_valid),
    .o_alu_start (o_alu_start),
    .o_alu_op    (o_alu_op),
    .o_rd_addr   (o_rd_addr),
    .o_rs1_addr  (o_rs1_addr),
    .o_rs2_addr  (o_rs2_addr),
    .i_exec_done (i_exec_done),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_illegal   (o_illegal),
    .o_retired   (o_retired),
    .o_fault     (o_fault)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_asserts++;
    n_fails++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Memory: a junk strobe during FETCH (must be ignored), then real data in the first WAIT_MEM cycle.
  initial begin
    logic [7:0] a;
    i_mem_valid = 1'b0;
    i_mem_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_en && o_mem_rd) begin
        a = o_mem_addr;
        i_mem_valid = 1'b1;
        i_mem_data  = 16'hFFFF;
        @(posedge clk); #1;
        i_mem_data  = prog[a];
        @(posedge clk); #1;
        i_mem_valid = 1'b0;
        i_mem_data  = 16'h0000;
      end
    end
  end

  initial begin
    i_exec_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_alu_start) begin
        repeat (exec_lat) @(posedge clk);
        #1 i_exec_done = 1'b1;
        @(posedge clk);
        #1 i_exec_done = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (o_mem_rd) begin
      last_rd_cyc = cyc;
      n_asserts++;
      if (exp_fetch_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_mem_rd: got addr %0h, expected no fetch", o_mem_addr);
      end else begin
        n_asserts--;
        check("fetch_addr", 32'(o_mem_addr), 32'(exp_fetch_q.pop_front()));
      end
    end
    if (o_alu_start) begin
      n_asserts++;
      if (exp_issue_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_alu_start: got op %0h, expected no issue", o_alu_op);
      end else begin
        n_asserts--;
        check("issue_fields", 32'({o_alu_op, o_rd_addr, o_rs1_addr, o_rs2_addr}),
              32'(exp_issue_q.pop_front()));
        check("issue_latency", 32'(cyc - last_rd_cyc), 32'd3);
      end
    end
    if (o_illegal) illegal_seen++;
  end

  task automatic wait_rd(input logic [7:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(o_mem_rd && o_mem_addr == a) && n < 4000);
    if (n >= 4000) timeout_fail("wait_mem_rd");
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < 200);
    if (n >= 200) timeout_fail("wait_idle");
  endtask

  task automatic wait_alu();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_alu_start && n < 200);
    if (n >= 200) timeout_fail("wait_alu_start");
  endtask

  task automatic wait_halt();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_halted && n < 200);
    if (n >= 200) timeout_fail("wait_halt");
  endtask

  task automatic run_until_rd(input logic [7:0] a);
    i_run = 1'b1;
    wait_rd(a);
    i_run = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [15:0] w;
    i_reset = 1'b0;
    i_run   = 1'b0;
    #1 i_reset = 1'b1;
    #1;
    check("rst_pc",      32'(o_mem_addr), 32'd0);
    check("rst_retired", 32'(o_retired), 32'd0);
    check("rst_flags",   32'({o_mem_rd, o_alu_start, o_illegal, o_halted, o_busy, o_fault}), 32'd0);
    check("rst_fields",  32'({o_alu_op, o_rd_addr, o_rs1_addr, o_rs2_addr}), 32'd0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    // Single instruction, run dropped after fetch starts.
    prog[0] = 16'h1234;
    exp_fetch_q.push_back(8'h00);
    exp_issue_q.push_back(16'h1234);
    i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    wait_idle();
    check("single_pc",      32'(o_mem_addr), 32'd1);
    check("single_retired", 32'(o_retired), 32'd1);
    check("single_fields",  32'({o_alu_op, o_rd_addr, o_rs1_addr, o_rs2_addr}), 32'h1234);

    // Resume from IDLE at the current pc.
    prog[1] = 16'h2345;
    prog[2] = 16'h3456;
    exp_fetch_q.push_back(8'h01);
    exp_fetch_q.push_back(8'h02);
    exp_issue_q.push_back(16'h2345);
    exp_issue_q.push_back(16'h3456);
    run_until_rd(8'h02);
    check("resume_pc",      32'(o_mem_addr), 32'd3);
    check("resume_retired", 32'(o_retired), 32'd3);

    // Illegal opcodes C/E/D are skipped without issue; B is the highest legal opcode.
    prog[3] = 16'hC000;
    prog[4] = 16'h0111;
    prog[5] = 16'hE123;
    prog[6] = 16'hD000;
    prog[7] = 16'hBFED;
    for (int i = 3; i <= 7; i++) exp_fetch_q.push_back(8'(i));
    exp_issue_q.push_back(16'h0111);
    exp_issue_q.push_back(16'hBFED);
    run_until_rd(8'h07);
    check("illegal_pc",      32'(o_mem_addr), 32'd8);
    check("illegal_retired", 32'(o_retired), 32'd5);
    check("illegal_count",   32'(illegal_seen), 32'd3);

    // Reset in EXEC_WAIT: immediate, and the late exec_done must not count.
    prog[8] = 16'h4321;
    exp_fetch_q.push_back(8'h08);
    exp_issue_q.push_back(16'h4321);
    exec_lat = 6;
    i_run = 1'b1;
    wait_alu();
    i_run = 1'b0;
    repeat (2) @(negedge clk);
    check("exec_wait_busy", 32'(o_busy), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("rst_exec_pc",      32'(o_mem_addr), 32'd0);
    check("rst_exec_retired", 32'(o_retired), 32'd0);
    check("rst_exec_busy",    32'(o_busy), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_pc",      32'(o_mem_addr), 32'd0);
    check("post_rst_retired", 32'(o_retired), 32'd0);
    check("post_rst_busy",    32'(o_busy), 32'd0);
    exec_lat = 1;

    // 256 instructions: pc and retired both wrap to 0.
    for (int i = 0; i < 256; i++) begin
      w = {4'(i % 12), 4'(i), 4'(i >> 4), ~4'(i)};
      prog[i] = w;
      exp_fetch_q.push_back(8'(i));
      exp_issue_q.push_back(w);
    end
    i_run = 1'b1;
    wait_rd(8'hFF);
    check("prewrap_retired", 32'(o_retired), 32'd255);
    i_run = 1'b0;
    wait_idle();
    check("wrap_pc",      32'(o_mem_addr), 32'd0);
    check("wrap_retired", 32'(o_retired), 32'd0);

    // HALT opcode: one issue, then frozen with no further fetches.
    prog[0] = 16'h0123;
    prog[1] = 16'hF000;
    exp_fetch_q.push_back(8'h00);
    exp_fetch_q.push_back(8'h01);
    exp_issue_q.push_back(16'h0123);
    i_run = 1'b1;
    wait_halt();
    repeat (10) @(negedge clk);
    check("halt_halted",  32'(o_halted), 32'd1);
    check("halt_pc",      32'(o_mem_addr), 32'd1);
    check("halt_busy",    32'(o_busy), 32'd0);
    check("halt_retired", 32'(o_retired), 32'd1);
    i_run = 1'b0;
    #2 i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("halt_rst_halted", 32'(o_halted), 32'd0);

    // Memory never answers.
    mem_en = 1'b0;
    exp_fetch_q.push_back(8'h00);
    i_run = 1'b1;
    wait_rd(8'h00);
    repeat (16) @(negedge clk);
    check("tmo_pre_fault", 32'(o_fault), 32'd0);
    check("tmo_pre_busy",  32'(o_busy), 32'd1);
    @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    check("tmo_fault",  32'(o_fault), 32'd1);
    check("tmo_halted", 32'(o_halted), 32'd1);
`else
    check("tmo_fault",  32'(o_fault), 32'd0);
    check("tmo_halted", 32'(o_halted), 32'd0);
    check("tmo_busy",   32'(o_busy), 32'd1);
`endif
    repeat (20) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    check("tmo_sticky_fault", 32'(o_fault), 32'd1);
`else
    check("tmo_still_waiting", 32'({o_busy, o_fault}), 32'b10);
`endif
    i_run = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    check("tmo_rst_fault", 32'(o_fault), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    check("fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);
    check("issue_q_empty", 32'(exp_issue_q.size()), 32'd0);
    check("illegal_total", 32'(illegal_seen), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
